// File: rtl/ndp_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ndp_pkg: shared FSM/SIMD encodings and result packing helper. Rev 1.0
// ----------------------------------------------------------------------------
package ndp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HOLD  = 3'd4
  } ndp_state_e;

  // DUAL splits every element into two independent half-width lanes
  typedef enum logic [1:0] {
    SIMD_FULL  = 2'd0,
    SIMD_DUAL  = 2'd1,
    SIMD_RSVD2 = 2'd2,
    SIMD_RSVD3 = 2'd3
  } simd_mode_e;

  function automatic int out_idx(input int r, input int c, input int cols);
    return r * cols + c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_buffer: fixed-depth delay line, one stage per clock. Rev 1.0
// ----------------------------------------------------------------------------
module fifo_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign out_data = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/ndp_skew_bank.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ndp_skew_bank: lane i delayed i+1 cycles; gated-off beats enter as zero. Rev 1.0
// ----------------------------------------------------------------------------
module ndp_skew_bank #(
  parameter int LANES = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_en,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic [LANES*WIDTH-1:0] out_data
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [WIDTH-1:0] lane_in;
    assign lane_in = in_en ? in_data[i*WIDTH +: WIDTH] : '0;

    fifo_buffer #(
      .WIDTH (WIDTH),
      .DEPTH (i + 1)
    ) u_dly (
      .clk      (clk),
      .reset    (reset),
      .in_data  (lane_in),
      .out_data (out_data[i*WIDTH +: WIDTH])
    );
  end

endmodule
`default_nettype wire

// File: rtl/systolic_array_align.sv
`default_nettype none
// ----------------------------------------------------------------------------
// systolic_array_align: output-stationary MAC grid, A flows right, B flows down. Rev 1.0
// ----------------------------------------------------------------------------
module systolic_array_align
  import ndp_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int ARR_WIDTH  = 4,
  parameter int ARR_HEIGHT = 4,
  parameter int SYS_WIDTH  = 64,
  parameter int SYS_HEIGHT = 1,
  parameter int MAC_LAT    = 1
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic [1:0]                                             simd_mode,
  input  logic [ARR_HEIGHT*SYS_HEIGHT*WIDTH-1:0]                 in_a,
  input  logic [ARR_WIDTH*SYS_WIDTH*WIDTH-1:0]                   in_b,
  output logic [ARR_HEIGHT*SYS_HEIGHT*ARR_WIDTH*SYS_WIDTH*WIDTH-1:0] out_c
);

  localparam int ROWS = ARR_HEIGHT * SYS_HEIGHT;
  localparam int COLS = ARR_WIDTH * SYS_WIDTH;
  localparam int HW   = WIDTH / 2;

  logic             dual;
  logic [WIDTH-1:0] a_bus [ROWS][COLS];
  logic [WIDTH-1:0] b_bus [ROWS][COLS];

  assign dual = (simd_mode == SIMD_DUAL);

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [WIDTH-1:0] a_in, b_in, prod_full, prod, prod_lat, acc_q, acc_d;
      logic [HW-1:0]    prod_hi, prod_lo;

      if (c == 0) begin : g_a_edge
        assign a_bus[r][c] = in_a[r*WIDTH +: WIDTH];
      end
      if (r == 0) begin : g_b_edge
        assign b_bus[r][c] = in_b[c*WIDTH +: WIDTH];
      end
      assign a_in = a_bus[r][c];
      assign b_in = b_bus[r][c];

      if (c < COLS - 1) begin : g_fwd_a
        logic [WIDTH-1:0] a_q, a_d;
        assign a_d = a_in;
        always_ff @(posedge clk or posedge reset) begin
          if (reset) a_q <= '0;
          else       a_q <= a_d;
        end
        assign a_bus[r][c+1] = a_q;
      end
      if (r < ROWS - 1) begin : g_fwd_b
        logic [WIDTH-1:0] b_q, b_d;
        assign b_d = b_in;
        always_ff @(posedge clk or posedge reset) begin
          if (reset) b_q <= '0;
          else       b_q <= b_d;
        end
        assign b_bus[r+1][c] = b_q;
      end

      assign prod_full = a_in * b_in;
      assign prod_hi   = a_in[WIDTH-1:HW] * b_in[WIDTH-1:HW];
      assign prod_lo   = a_in[HW-1:0] * b_in[HW-1:0];
      assign prod      = dual ? {prod_hi, prod_lo} : prod_full;

      if (MAC_LAT > 1) begin : g_mac_pipe
        logic [WIDTH-1:0] pipe_q [MAC_LAT-1];
        logic [WIDTH-1:0] pipe_d [MAC_LAT-1];
        always_comb begin
          pipe_d[0] = prod;
          for (int i = 1; i < MAC_LAT - 1; i++) begin
            pipe_d[i] = pipe_q[i-1];
          end
        end
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            for (int i = 0; i < MAC_LAT - 1; i++) pipe_q[i] <= '0;
          end else begin
            pipe_q <= pipe_d;
          end
        end
        assign prod_lat = pipe_q[MAC_LAT-2];
      end else begin : g_mac_direct
        assign prod_lat = prod;
      end

      // Dual mode drops the carry between halves so each lane wraps on its own
      always_comb begin
        acc_d = acc_q + prod_lat;
        if (dual) begin
          acc_d = {acc_q[WIDTH-1:HW] + prod_lat[WIDTH-1:HW],
                   acc_q[HW-1:0] + prod_lat[HW-1:0]};
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) acc_q <= '0;
        else       acc_q <= acc_d;
      end

      assign out_c[out_idx(r, c, COLS)*WIDTH +: WIDTH] = acc_q;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ndp_tile_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ndp_tile_engine: streams one tile through a skewed systolic array, FSM-sequenced. Rev 1.0
// ----------------------------------------------------------------------------
module ndp_tile_engine
  import ndp_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int ARR_WIDTH  = 4,
  parameter int ARR_HEIGHT = 4,
  parameter int SYS_WIDTH  = 64,
  parameter int SYS_HEIGHT = 1,
  parameter int K_W        = 9,
  parameter int MAC_LAT    = 1
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic                                                   start,
  input  logic [K_W-1:0]                                         k_len,
  input  logic [1:0]                                             SIMD_control,
  input  logic                                                   in_valid,
  output logic                                                   in_ready,
  input  logic [ARR_HEIGHT*SYS_HEIGHT*WIDTH-1:0]                 in_a,
  input  logic [ARR_WIDTH*SYS_WIDTH*WIDTH-1:0]                   in_b,
  output logic                                                   busy,
  output logic                                                   out_valid,
  input  logic                                                   out_ready,
  output logic [ARR_HEIGHT*SYS_HEIGHT*ARR_WIDTH*SYS_WIDTH*WIDTH-1:0] out_c,
  output logic                                                   calc_done_flag
);

  localparam int ROWS      = ARR_HEIGHT * SYS_HEIGHT;
  localparam int COLS      = ARR_WIDTH * SYS_WIDTH;
  localparam int C_W       = ROWS * COLS * WIDTH;
  localparam int DRAIN_CYC = ROWS + COLS + MAC_LAT;
  localparam int DRN_W     = $clog2(DRAIN_CYC + 1);
  localparam int CNT_W     = (K_W > DRN_W) ? K_W : DRN_W;

  ndp_state_e       state_q, state_d;
  simd_mode_e       simd_q, simd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, k_last;
  logic [K_W-1:0]   k_len_q, k_len_d;
  logic             clr_q, clr_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             out_valid_q, out_valid_d;
  logic             done_q, done_d;
  logic [C_W-1:0]   out_c_q, out_c_d;
  logic             capture;
  logic             beat_acc;
  logic             arr_rst;
  logic [ROWS*WIDTH-1:0] a_skew;
  logic [COLS*WIDTH-1:0] b_skew;
  logic [C_W-1:0]        arr_c;

  assign beat_acc = in_valid & in_ready_q;
  assign k_last   = CNT_W'(k_len_q) - CNT_W'(1);
  // Clear comes straight from a flop so the array's async reset never glitches
  assign arr_rst  = reset | clr_q;

  ndp_skew_bank #(.LANES(ROWS), .WIDTH(WIDTH)) u_skew_a (
    .clk      (clk),
    .reset    (reset),
    .in_en    (beat_acc),
    .in_data  (in_a),
    .out_data (a_skew)
  );

  ndp_skew_bank #(.LANES(COLS), .WIDTH(WIDTH)) u_skew_b (
    .clk      (clk),
    .reset    (reset),
    .in_en    (beat_acc),
    .in_data  (in_b),
    .out_data (b_skew)
  );

  systolic_array_align #(
    .WIDTH      (WIDTH),
    .ARR_WIDTH  (ARR_WIDTH),
    .ARR_HEIGHT (ARR_HEIGHT),
    .SYS_WIDTH  (SYS_WIDTH),
    .SYS_HEIGHT (SYS_HEIGHT),
    .MAC_LAT    (MAC_LAT)
  ) u_array (
    .clk       (clk),
    .reset     (arr_rst),
    .simd_mode (simd_q),
    .in_a      (a_skew),
    .in_b      (b_skew),
    .out_c     (arr_c)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_len_d = k_len_q;
    simd_d  = simd_q;
    capture = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && (k_len != '0)) begin
          k_len_d = k_len;
          simd_d  = simd_mode_e'(SIMD_control);
          cnt_d   = '0;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: state_d = ST_FEED;
      ST_FEED: begin
        if (beat_acc) begin
          if (cnt_q == k_last) begin
            cnt_d   = '0;
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (cnt_q == CNT_W'(DRAIN_CYC - 1)) begin
          cnt_d   = '0;
          capture = 1'b1;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered versions of the next state
    clr_d       = (state_d == ST_CLEAR);
    in_ready_d  = (state_d == ST_FEED);
    busy_d      = (state_d != ST_IDLE);
    out_valid_d = (state_d == ST_HOLD);
    done_d      = capture;
    out_c_d     = capture ? arr_c : out_c_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      k_len_q     <= '0;
      simd_q      <= SIMD_FULL;
      clr_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      out_c_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_len_q     <= k_len_d;
      simd_q      <= simd_d;
      clr_q       <= clr_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      out_c_q     <= out_c_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign busy           = busy_q;
  assign out_valid      = out_valid_q;
  assign calc_done_flag = done_q;
  assign out_c          = out_c_q;

endmodule
`default_nettype wire

// File: tb/tb_ndp_tile_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ndp_tile_engine: random tiles against a plain matrix-multiply model. Rev 1.0
// ----------------------------------------------------------------------------
module tb_ndp_tile_engine;
  import ndp_pkg::*;

  localparam int WIDTH      = 8;
  localparam int ARR_WIDTH  = 2;
  localparam int ARR_HEIGHT = 2;
  localparam int SYS_WIDTH  = 1;
  localparam int SYS_HEIGHT = 1;
  localparam int K_W        = 4;
  localparam int MAC_LAT    = 1;
  localparam int ROWS       = ARR_HEIGHT * SYS_HEIGHT;
  localparam int COLS       = ARR_WIDTH * SYS_WIDTH;
  localparam int DRAIN_CYC  = ROWS + COLS + MAC_LAT;
  localparam int KMAX       = (1 << K_W) - 1;
  localparam int A_W        = ROWS * WIDTH;
  localparam int B_W        = COLS * WIDTH;
  localparam int C_W        = ROWS * COLS * WIDTH;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [K_W-1:0] k_len = '0;
  logic [1:0]     simd = 2'd0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [A_W-1:0] in_a = '0;
  logic [B_W-1:0] in_b = '0;
  logic           busy;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [C_W-1:0] out_c;
  logic           calc_done_flag;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int ta [ROWS][KMAX];
  int tb [KMAX][COLS];

  ndp_tile_engine #(
    .WIDTH(WIDTH), .ARR_WIDTH(ARR_WIDTH), .ARR_HEIGHT(ARR_HEIGHT),
    .SYS_WIDTH(SYS_WIDTH), .SYS_HEIGHT(SYS_HEIGHT), .K_W(K_W), .MAC_LAT(MAC_LAT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .k_len(k_len), .SIMD_control(simd),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c),
    .calc_done_flag(calc_done_flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // C = A x B, element-wise modulo 2^WIDTH, or two independent half lanes in dual mode
  function automatic logic [C_W-1:0] model_c(input int k, input int mode);
    logic [C_W-1:0] res;
    int full, hi, lo, elem;
    int fm, hm;
    fm  = 1 << WIDTH;
    hm  = 1 << (WIDTH / 2);
    res = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        full = 0; hi = 0; lo = 0;
        for (int kk = 0; kk < k; kk++) begin
          full += ta[r][kk] * tb[kk][c];
          hi   += (ta[r][kk] / hm) * (tb[kk][c] / hm);
          lo   += (ta[r][kk] % hm) * (tb[kk][c] % hm);
        end
        elem = (mode == 1) ? ((hi % hm) * hm + (lo % hm)) : (full % fm);
        res[out_idx(r, c, COLS)*WIDTH +: WIDTH] = elem[WIDTH-1:0];
      end
    end
    return res;
  endfunction

  task automatic fill_rand(input int k);
    for (int r = 0; r < ROWS; r++)
      for (int kk = 0; kk < k; kk++) ta[r][kk] = $urandom_range(0, (1 << WIDTH) - 1);
    for (int kk = 0; kk < k; kk++)
      for (int c = 0; c < COLS; c++) tb[kk][c] = $urandom_range(0, (1 << WIDTH) - 1);
  endtask

  task automatic drive_beat(input int kk);
    for (int r = 0; r < ROWS; r++) in_a[r*WIDTH +: WIDTH] = ta[r][kk][WIDTH-1:0];
    for (int c = 0; c < COLS; c++) in_b[c*WIDTH +: WIDTH] = tb[kk][c][WIDTH-1:0];
  endtask

  task automatic run_tile(input string tag, input int k, input int mode,
                          input int bub1, input int bub_rand, input int hold);
    logic [C_W-1:0] exp;
    int t0, nb, n, nbub;
    exp   = model_c(k, mode);
    start = 1'b1;
    k_len = K_W'(k);
    simd  = 2'(mode);
    t0    = cyc;
    tick();
    start = 1'b0;
    chk({tag, "_clear_busy"}, busy, 1);
    chk({tag, "_clear_rdy"}, in_ready, 0);
    tick();
    chk({tag, "_feed_rdy"}, in_ready, 1);
    nb = 0;
    for (int kk = 0; kk < k; kk++) begin
      nbub = (kk == 1) ? bub1 : 0;
      if (bub_rand > 0) nbub += $urandom_range(0, bub_rand);
      in_valid = 1'b0;
      in_a = A_W'($urandom);
      in_b = B_W'($urandom);
      repeat (nbub) begin
        tick();
        nb++;
      end
      drive_beat(kk);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
    end
    chk({tag, "_drain_rdy"}, in_ready, 0);
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    if (!out_valid) begin
      chk({tag, "_timeout"}, out_valid, 1);
      return;
    end
    chk({tag, "_latency"}, cyc - t0, 2 + k + DRAIN_CYC + nb);
    chk({tag, "_done"}, calc_done_flag, 1);
    chk({tag, "_c"}, out_c, exp);
    start = 1'b1;
    repeat (hold) tick();
    if (hold > 0) begin
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_c"}, out_c, exp);
      chk({tag, "_hold_pulse"}, calc_done_flag, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    chk({tag, "_ov_fall"}, out_valid, 0);
    chk({tag, "_pulse_fall"}, calc_done_flag, 0);
    chk({tag, "_idle"}, busy, 0);
    tick();
    chk({tag, "_start_ignored"}, busy, 0);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", calc_done_flag, 0);
    chk("rst_out_c", out_c, 0);
    reset = 1'b0;
    tick();

    ta[0][0] = 1; ta[0][1] = 2; ta[1][0] = 3; ta[1][1] = 4;
    tb[0][0] = 5; tb[0][1] = 6; tb[1][0] = 7; tb[1][1] = 8;
    run_tile("basic", 2, 0, 0, 0, 0);
    run_tile("bubble", 2, 0, 3, 0, 0);

    ta[0][0] = 1;  ta[0][1] = 0;  ta[1][0] = 0;  ta[1][1] = 1;
    tb[0][0] = 9;  tb[0][1] = 10; tb[1][0] = 11; tb[1][1] = 12;
    run_tile("b2b", 2, 0, 0, 0, 0);

    start = 1'b1;
    k_len = '0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("k0_busy", busy, 0);
      chk("k0_rdy", in_ready, 0);
      tick();
    end

    ta[0][0] = 2; ta[1][0] = 3; tb[0][0] = 4; tb[0][1] = 5;
    run_tile("k1", 1, 0, 0, 0, 0);

    ta[0][0] = 1; ta[0][1] = 2; ta[1][0] = 3; ta[1][1] = 4;
    tb[0][0] = 5; tb[0][1] = 6; tb[1][0] = 7; tb[1][1] = 8;
    run_tile("backpr", 2, 0, 0, 0, 20);

    // Abort a tile in FEED with an asynchronous reset
    fill_rand(4);
    start = 1'b1;
    k_len = K_W'(4);
    simd  = 2'd0;
    tick();
    start = 1'b0;
    tick();
    drive_beat(0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_rdy", in_ready, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_done", calc_done_flag, 0);
    chk("abort_c", out_c, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("abort_idle", busy, 0);
    fill_rand(3);
    run_tile("fresh", 3, 0, 0, 0, 0);

    fill_rand(2);
    ta[0][0] = 16; ta[0][1] = 16; tb[0][0] = 16; tb[1][0] = 16;
    run_tile("overflow", 2, 0, 0, 0, 0);

    fill_rand(KMAX);
    run_tile("kmax", KMAX, 0, 0, 1, 1);

    fill_rand(5);
    run_tile("dual", 5, 1, 0, 1, 0);

    for (int t = 0; t < 25; t++) begin
      int k;
      k = $urandom_range(1, KMAX);
      fill_rand(k);
      run_tile("rand", k, $urandom_range(0, 1), 0, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
